// File: rtl/relogio_ctrl.sv
// Timekeeping controller: 1 Hz prescaler, seconds count, button conditioning and
// RUN/SET_H/SET_M mode FSM driving minute/hour counter enables and the display blink flag.
module relogio_ctrl #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic       maq_h_clock,
    input  logic       maq_h_reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] min_lsd,
    input  logic [2:0] min_msd,
    output logic       tick_1hz,
    output logic [5:0] sec_o,
    output logic       m_en,
    output logic       h_en,
    output logic [1:0] mode_o,
    output logic       blink
);

    localparam int unsigned PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int unsigned NBTN    = 2;
    localparam int unsigned BTN_MOD = 0;
    localparam int unsigned BTN_INC = 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2 - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [5:0]    SEC_LAST   = 6'd59;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [5:0]         sec_q, sec_d;
    logic               tick_q, tick_d;
    logic               m_en_q, m_en_d;
    logic               h_en_q, h_en_d;
    logic               phase_q, phase_d;
    logic               blink_q, blink_d;
    logic [NBTN-1:0]    sync1_q, sync1_d;
    logic [NBTN-1:0]    sync2_q, sync2_d;
    logic [NBTN-1:0]    deb_q, deb_d;
    logic [DW-1:0]      deb_cnt_q [NBTN];
    logic [DW-1:0]      deb_cnt_d [NBTN];
    logic [NBTN-1:0]    press_c;
    logic               wrap_c;

    // Synchronize and debounce both buttons; a press is the debounced 0->1 update cycle.
    always_comb begin
        sync1_d   = {btn_inc, btn_mode};
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        press_c   = '0;
        for (int b = 0; b < int'(NBTN); b++) begin
            if (sync2_q[b] == deb_q[b]) begin
                deb_cnt_d[b] = '0;
            end else if (deb_cnt_q[b] == DEB_LAST) begin
                deb_d[b]     = sync2_q[b];
                deb_cnt_d[b] = '0;
                press_c[b]   = sync2_q[b];
            end else begin
                deb_cnt_d[b] = deb_cnt_q[b] + DW'(1);
            end
        end
    end

    // Mode FSM next state together with prescaler, seconds and enable pulses.
    always_comb begin
        wrap_c  = (presc_q == PRESC_LAST);
        mode_d  = mode_q;
        presc_d = wrap_c ? '0 : presc_q + PW'(1);
        sec_d   = sec_q;
        tick_d  = wrap_c;
        m_en_d  = 1'b0;
        h_en_d  = 1'b0;
        phase_d = phase_q ^ (wrap_c || (presc_q == PRESC_HALF));

        case (mode_q)
            RUN: begin
                if (press_c[BTN_MOD]) begin
                    mode_d = SET_H;
                end
                if (wrap_c) begin
                    if (sec_q == SEC_LAST) begin
                        sec_d  = '0;
                        m_en_d = 1'b1;
                        h_en_d = (min_msd == 3'd5) && (min_lsd == 4'd9);
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
            end
            SET_H: begin
                if (press_c[BTN_MOD]) begin
                    mode_d = SET_M;
                end else if (press_c[BTN_INC]) begin
                    h_en_d = 1'b1;
                end
            end
            SET_M: begin
                // Leaving set mode restarts the second from zero.
                if (press_c[BTN_MOD]) begin
                    mode_d  = RUN;
                    sec_d   = '0;
                    presc_d = '0;
                end else if (press_c[BTN_INC]) begin
                    m_en_d = 1'b1;
                end
            end
            default: begin
                mode_d = RUN;
            end
        endcase

        blink_d = (mode_d == RUN) || phase_d;
    end

    always_ff @(posedge maq_h_clock or negedge maq_h_reset) begin
        if (!maq_h_reset) begin
            mode_q    <= RUN;
            presc_q   <= '0;
            sec_q     <= '0;
            tick_q    <= 1'b0;
            m_en_q    <= 1'b0;
            h_en_q    <= 1'b0;
            phase_q   <= 1'b0;
            blink_q   <= 1'b1;
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_cnt_q <= '{default: '0};
        end else begin
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            tick_q    <= tick_d;
            m_en_q    <= m_en_d;
            h_en_q    <= h_en_d;
            phase_q   <= phase_d;
            blink_q   <= blink_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign tick_1hz = tick_q;
    assign sec_o    = sec_q;
    assign m_en     = m_en_q;
    assign h_en     = h_en_q;
    assign mode_o   = mode_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_relogio_ctrl.sv
// Bench for relogio_ctrl: directed scenarios plus random button/minute activity,
// every cycle compared against a behavioural model of the timekeeping rules.
module tb_relogio_ctrl;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] min_lsd = 4'd0;
    logic [2:0] min_msd = 3'd0;
    logic       tick_1hz;
    logic [5:0] sec_o;
    logic       m_en;
    logic       h_en;
    logic [1:0] mode_o;
    logic       blink;

    relogio_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .DEB_CYCLES(DEB)
    ) dut (
        .maq_h_clock(clk),
        .maq_h_reset(rst_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .min_lsd    (min_lsd),
        .min_msd    (min_msd),
        .tick_1hz   (tick_1hz),
        .sec_o      (sec_o),
        .m_en       (m_en),
        .h_en       (h_en),
        .mode_o     (mode_o),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_m = 0, n_h = 0, n_mh = 0;
    bit prev_m = 1'b0, prev_h = 1'b0;

    // Behavioural model state (mode: 0 RUN, 1 SET_H, 2 SET_M).
    int m_presc, m_sec, m_mode;
    bit m_tick, m_men, m_hen, m_phase, m_blink;
    bit s1[2], s2[2], deb[2];
    int run[2];

    int  first_tick;
    int  toggles;
    bit  last_blink;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_presc = 0; m_sec = 0; m_mode = 0;
        m_tick = 0; m_men = 0; m_hen = 0; m_phase = 0; m_blink = 1;
        for (int b = 0; b < 2; b++) begin
            s1[b] = 0; s2[b] = 0; deb[b] = 0; run[b] = 0;
        end
    endtask

    task automatic model_edge();
        bit raw[2];
        bit ev[2];
        bit wrap;
        raw[0] = btn_mode;
        raw[1] = btn_inc;
        for (int b = 0; b < 2; b++) begin
            ev[b] = 0;
            if (s2[b] != deb[b]) begin
                run[b]++;
                if (run[b] == DEB) begin
                    deb[b] = s2[b];
                    run[b] = 0;
                    ev[b]  = deb[b];
                end
            end else begin
                run[b] = 0;
            end
            s2[b] = s1[b];
            s1[b] = raw[b];
        end
        wrap = (m_presc == CLK_HZ - 1);
        if (m_presc == CLK_HZ / 2 - 1 || wrap) m_phase = !m_phase;
        m_presc = (m_presc + 1) % CLK_HZ;
        m_tick = wrap;
        m_men = 0;
        m_hen = 0;
        if (m_mode == 0) begin
            if (wrap) begin
                m_sec = (m_sec + 1) % 60;
                if (m_sec == 0) begin
                    m_men = 1;
                    m_hen = (min_msd == 3'd5) && (min_lsd == 4'd9);
                end
            end
            if (ev[0]) m_mode = 1;
        end else if (ev[0]) begin
            if (m_mode == 2) begin
                m_sec = 0;
                m_presc = 0;
            end
            m_mode = (m_mode + 1) % 3;
        end else if (ev[1]) begin
            if (m_mode == 1) m_hen = 1;
            else m_men = 1;
        end
        m_blink = (m_mode == 0) || m_phase;
    endtask

    task automatic check_all();
        chk("tick_1hz", 32'(tick_1hz), 32'(m_tick));
        chk("sec_o", 32'(sec_o), m_sec);
        chk("m_en", 32'(m_en), 32'(m_men));
        chk("h_en", 32'(h_en), 32'(m_hen));
        chk("mode_o", 32'(mode_o), m_mode);
        chk("blink", 32'(blink), 32'(m_blink));
        if (prev_m) chk("m_en_consecutive", 32'(m_en), 0);
        if (prev_h) chk("h_en_consecutive", 32'(h_en), 0);
        prev_m = (m_en === 1'b1);
        prev_h = (h_en === 1'b1);
        if (m_en === 1'b1) n_m++;
        if (h_en === 1'b1) n_h++;
        if (m_en === 1'b1 && h_en === 1'b1) n_mh++;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic clear_counts();
        n_m = 0; n_h = 0; n_mh = 0;
    endtask

    task automatic press(input bit pm, input bit pi);
        btn_mode = pm;
        btn_inc  = pi;
        repeat (8) cyc();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (8) cyc();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("reset_mode", 32'(mode_o), 0);
        chk("reset_blink", 32'(blink), 1);
        chk("reset_sec", 32'(sec_o), 0);

        // First tick ten cycles after release; then one full minute with no carry.
        rst_n = 1'b1;
        min_msd = 3'd0;
        min_lsd = 4'd5;
        first_tick = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (tick_1hz === 1'b1 && first_tick < 0) first_tick = i;
        end
        chk("first_tick_cycle", first_tick, 10);
        repeat (585) cyc();
        chk("wrap_m_en_count", n_m, 1);
        chk("wrap_h_en_count", n_h, 0);
        chk("sec_after_wrap", 32'(sec_o), 0);

        // Minute 59 at the wrap carries into the hour.
        min_msd = 3'd5;
        min_lsd = 4'd9;
        clear_counts();
        repeat (600) cyc();
        chk("carry_both_count", n_mh, 1);
        chk("carry_m_count", n_m, 1);
        chk("carry_h_count", n_h, 1);

        // Short glitch is rejected; long press enters SET_H.
        btn_mode = 1'b1;
        repeat (2) cyc();
        btn_mode = 1'b0;
        repeat (10) cyc();
        chk("glitch_mode", 32'(mode_o), 0);
        press(1'b1, 1'b0);
        chk("set_h_mode", 32'(mode_o), 1);

        last_blink = blink;
        toggles = 0;
        repeat (20) begin
            cyc();
            if (blink !== last_blink) toggles++;
            last_blink = blink;
        end
        chk("blink_toggles", toggles, 4);

        clear_counts();
        press(1'b0, 1'b1);
        chk("set_h_h_count", n_h, 1);
        chk("set_h_m_count", n_m, 0);

        press(1'b1, 1'b0);
        chk("set_m_mode", 32'(mode_o), 2);
        clear_counts();
        press(1'b0, 1'b1);
        chk("set_m_m_count", n_m, 1);
        chk("set_m_h_count", n_h, 0);

        // Mode and inc together: mode wins and seconds restart.
        clear_counts();
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        repeat (6) cyc();
        chk("simul_mode", 32'(mode_o), 0);
        chk("simul_sec", 32'(sec_o), 0);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (8) cyc();
        chk("simul_m_count", n_m, 0);
        chk("simul_h_count", n_h, 0);

        // Reset in SET_M with the mode button held through release.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("pre_reset_mode", 32'(mode_o), 2);
        btn_mode = 1'b1;
        repeat (3) cyc();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("mid_reset_mode", 32'(mode_o), 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("held_not_yet", 32'(mode_o), 0);
        cyc();
        chk("held_redebounced", 32'(mode_o), 1);
        btn_mode = 1'b0;
        repeat (8) cyc();

        // Random button activity, minute values and occasional resets.
        for (int it = 0; it < 300; it++) begin
            btn_mode = 1'($urandom_range(0, 1));
            btn_inc  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                min_msd = 3'($urandom_range(0, 5));
                min_lsd = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                cyc();
                rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 12)) cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
